// File: rtl/prog_loader_if.sv
// Host byte-stream channel into the program loader: valid/ready handshake
// carrying one byte per transfer.
interface prog_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: parses A5/LEN/data/checksum frames from the host,
// writes 32-bit words into instruction memory and runs the core until halt.
module prog_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  prog_loader_if.slave      host,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_en,
  input  logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [7:0]  START = 8'hA5;
  localparam logic [31:0] CAP   = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  state_t          state;
  logic [15:0]     n_len;
  logic [ADDR_W:0] word_idx;
  logic [1:0]      byte_idx;
  logic [23:0]     asm_word;
  logic [7:0]      csum;

  logic [15:0]     len_next;
  logic            len_bad;
  logic            last_word;

  // Outputs decoded from the state register only, never from s_valid.
  assign host.s_ready = (state != S_WRITE) && (state != S_RUN);
  assign cpu_en       = (state == S_RUN);
  assign busy         = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                        (state == S_DATA)   || (state == S_WRITE)  ||
                        (state == S_CSUM);

  assign len_next  = {host.s_data, n_len[7:0]};
  assign len_bad   = (len_next == 16'd0) || ({16'd0, len_next} > CAP);
  assign last_word = ({{(31 - ADDR_W){1'b0}}, word_idx} + 32'd1) == {16'd0, n_len};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      n_len      <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      asm_word   <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_ERR: begin
          if (host.s_valid && host.s_data == START) begin
            state    <= S_LEN_LO;
            done     <= 1'b0;
            err      <= 1'b0;
            csum     <= '0;
            word_idx <= '0;
            byte_idx <= '0;
          end
        end
        S_LEN_LO: begin
          if (host.s_valid) begin
            n_len[7:0] <= host.s_data;
            state      <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (host.s_valid) begin
            n_len[15:8] <= host.s_data;
            if (len_bad) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (host.s_valid) begin
            csum     <= csum ^ host.s_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_word[7:0]   <= host.s_data;
              2'd1: asm_word[15:8]  <= host.s_data;
              2'd2: asm_word[23:16] <= host.s_data;
              default: begin
                // Top lane goes straight into the write data; no need to hold it.
                imem_we    <= 1'b1;
                imem_addr  <= word_idx[ADDR_W-1:0];
                imem_wdata <= {host.s_data, asm_word};
                state      <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          word_idx <= word_idx + {{ADDR_W{1'b0}}, 1'b1};
          state    <= last_word ? S_CSUM : S_DATA;
        end
        S_CSUM: begin
          if (host.s_valid) begin
            if (host.s_data == csum) begin
              state <= S_RUN;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (cpu_halt) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: randomized host frames checked every
// cycle against a byte-position model of the frame format.
module tb_prog_loader;
  localparam int unsigned ADDR_W = 2;
  localparam int          CAP    = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_en;
  logic              cpu_halt;
  logic              busy;
  logic              done;
  logic              err;

  prog_loader_if bus ();

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .host      (bus),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_en    (cpu_en),
    .cpu_halt  (cpu_halt),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position of the next byte within the current frame decides its meaning.
  bit          m_in_frame, m_wr, m_run, m_done, m_err;
  int          m_pos, m_n;
  logic [7:0]  m_csum;
  logic [31:0] m_word, m_wdata;
  int          m_waddr;
  logic [31:0] m_mem   [CAP];
  bit          m_mem_v [CAP];
  logic [31:0] dut_mem [CAP];
  int          dut_wr_cnt = 0;

  task automatic model_reset();
    m_in_frame = 0; m_wr = 0; m_run = 0; m_done = 0; m_err = 0;
    m_pos = 0; m_n = 0; m_csum = '0; m_word = '0; m_wdata = '0; m_waddr = 0;
  endtask

  task automatic model_step(input bit valid, input logic [7:0] data, input bit halt);
    int k;
    if (m_wr) begin
      m_wr = 0;
    end else if (m_run) begin
      if (halt) begin m_run = 0; m_done = 1; end
    end else if (valid) begin
      if (!m_in_frame) begin
        if (data == 8'hA5) begin
          m_in_frame = 1; m_pos = 1; m_done = 0; m_err = 0; m_csum = '0; m_n = 0;
        end
      end else begin
        if (m_pos == 1) begin
          m_n = int'(data);
        end else if (m_pos == 2) begin
          m_n = m_n + 256 * int'(data);
          if (m_n == 0 || m_n > CAP) begin m_in_frame = 0; m_err = 1; end
        end else if (m_pos < 3 + 4 * m_n) begin
          k = m_pos - 3;
          m_csum = m_csum ^ data;
          m_word[8*(k%4) +: 8] = data;
          if (k % 4 == 3) begin
            m_wr = 1; m_waddr = k / 4; m_wdata = m_word;
            m_mem[k/4] = m_word; m_mem_v[k/4] = 1;
          end
        end else begin
          m_in_frame = 0;
          if (data == m_csum) m_run = 1; else m_err = 1;
        end
        m_pos++;
      end
    end
  endtask

  initial begin
    for (int a = 0; a < CAP; a++) begin m_mem_v[a] = 0; m_mem[a] = '0; dut_mem[a] = '0; end
    model_reset();
  end

  // Single compare process: outputs settle between edges, inputs are stable here.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      chk("rst_imem_we", 32'(imem_we), 32'd0);
      chk("rst_imem_addr", 32'(imem_addr), 32'd0);
      chk("rst_imem_wdata", imem_wdata, 32'd0);
      chk("rst_cpu_en", 32'(cpu_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
    end else begin
      chk("s_ready", 32'(bus.s_ready), 32'(!m_wr && !m_run));
      chk("imem_we", 32'(imem_we), 32'(m_wr));
      chk("cpu_en", 32'(cpu_en), 32'(m_run));
      chk("busy", 32'(busy), 32'(m_in_frame));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      if (m_wr) begin
        chk("imem_addr", 32'(imem_addr), 32'(m_waddr));
        chk("imem_wdata", imem_wdata, m_wdata);
      end
      if (imem_we) begin
        dut_wr_cnt++;
        dut_mem[imem_addr] = imem_wdata;
      end
      model_step(bus.s_valid, bus.s_data, cpu_halt);
    end
  end

  function automatic logic [7:0] xsum(input logic [31:0] w[$]);
    logic [7:0] s = '0;
    foreach (w[i]) s = s ^ w[i][7:0] ^ w[i][15:8] ^ w[i][23:16] ^ w[i][31:24];
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int n = 0;
    int g = $urandom_range(0, maxgap);
    bus.s_valid = 1'b0;
    repeat (g) begin @(posedge clk); #1; end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    @(negedge clk);
    while (!bus.s_ready && n < 60) begin @(negedge clk); n++; end
    if (!bus.s_ready) chk("s_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'($urandom);
  endtask

  task automatic send_frame(input logic [31:0] w[$], input bit bad, input int maxgap);
    logic [7:0] c = xsum(w) ^ (bad ? 8'h01 : 8'h00);
    int n = w.size();
    send_byte(8'hA5, maxgap);
    send_byte(n[7:0], maxgap);
    send_byte(n[15:8], maxgap);
    foreach (w[i]) for (int j = 0; j < 4; j++) send_byte(w[i][8*j +: 8], maxgap);
    send_byte(c, maxgap);
  endtask

  task automatic wait_cpu_en(input bit hold_expected);
    int n = 0;
    @(negedge clk);
    while (!cpu_en && n < 60) begin @(negedge clk); n++; end
    if (!cpu_en) chk("cpu_en_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!hold_expected) begin
      cpu_halt = 1'b1;
      @(posedge clk); #1;
    end
    cpu_halt = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [31:0] w[$];
    int cnt0;
    rst_n = 1'b0; cpu_halt = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Single word A5 01 00 13 00 00 7F 6C
    w = {32'h7F000013};
    chk("xsum_single", 32'(xsum(w)), 32'h6C);
    cnt0 = dut_wr_cnt;
    send_frame(w, 0, 0);
    wait_cpu_en(0);
    chk("single_wr_cnt", 32'(dut_wr_cnt - cnt0), 32'd1);
    chk("single_word", dut_mem[0], 32'h7F000013);
    chk("single_done", 32'(done), 32'd1);

    // Three words with gaps
    w = {32'h11223344, 32'hAABBCCDD, 32'hFFFFFFFF};
    chk("xsum_three", 32'(xsum(w)), 32'h44);
    send_frame(w, 0, 3);
    wait_cpu_en(0);
    chk("three_w0", dut_mem[0], 32'h11223344);
    chk("three_w1", dut_mem[1], 32'hAABBCCDD);
    chk("three_w2", dut_mem[2], 32'hFFFFFFFF);

    // Bad checksum, then a good frame
    w = {32'h7F000013};
    cnt0 = dut_wr_cnt;
    send_frame(w, 1, 0);
    idle(3);
    chk("bad_wr_cnt", 32'(dut_wr_cnt - cnt0), 32'd1);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_cpu_en", 32'(cpu_en), 32'd0);
    send_frame(w, 0, 1);
    wait_cpu_en(0);

    // Length bounds
    cnt0 = dut_wr_cnt;
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    idle(2);
    chk("n0_err", 32'(err), 32'd1);
    chk("n0_wr_cnt", 32'(dut_wr_cnt - cnt0), 32'd0);
    send_byte(8'hA5, 0); send_byte(8'h05, 0); send_byte(8'h00, 0);
    idle(2);
    chk("n5_err", 32'(err), 32'd1);
    w = {};
    for (int i = 0; i < 4; i++) w.push_back($urandom);
    cnt0 = dut_wr_cnt;
    send_frame(w, 0, 1);
    wait_cpu_en(0);
    chk("n4_wr_cnt", 32'(dut_wr_cnt - cnt0), 32'd4);

    // Garbage, then reset in the middle of DATA
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h5A, 0);
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h13, 0);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    w = {32'hDEADBEEF};
    send_frame(w, 0, 0);
    wait_cpu_en(0);
    chk("post_rst_word", dut_mem[0], 32'hDEADBEEF);

    // cpu_halt held high through the load
    cpu_halt = 1'b1;
    w = {32'h00000093, 32'h12345678};
    send_frame(w, 0, 2);
    wait_cpu_en(1);
    chk("halt_held_done", 32'(done), 32'd1);
    send_frame(w, 0, 0);
    wait_cpu_en(0);

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      int  n    = $urandom_range(0, 5);
      bit  bad  = ($urandom_range(0, 3) == 0);
      int  junk = $urandom_range(0, 3);
      for (int j = 0; j < junk; j++) begin
        logic [7:0] b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        send_byte(b, 2);
      end
      if (n == 0 || n > CAP) begin
        send_byte(8'hA5, 2); send_byte(n[7:0], 2); send_byte(8'h00, 2);
        idle(2);
      end else begin
        w = {};
        for (int i = 0; i < n; i++) w.push_back($urandom);
        send_frame(w, bad, 3);
        if (bad) idle(2); else wait_cpu_en(0);
      end
    end

    idle(2);
    for (int a = 0; a < CAP; a++)
      if (m_mem_v[a]) chk("mem_scoreboard", dut_mem[a], m_mem[a]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader for the pipelined RISC core. It accepts a framed byte stream from the host and assembles the bytes into 32-bit instruction words. It writes those words into instruction memory through a write port, which is the write side of the memory the core's fetch stage reads. After a checksum-verified load it enables the core, then returns to idle when the core reports halt.

## Interface
- ADDR_W, 10, instruction-memory word-address width; capacity 2**ADDR_W words
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  host byte valid
- s_data  in  8  host byte
- s_ready  out  1  loader can accept a byte; a transfer happens on posedge when s_valid & s_ready
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address of the write
- imem_wdata  out  32  instruction word
- cpu_en  out  1  core run enable; 0 holds the core in reset/disabled
- cpu_halt  in  1  core halt flag
- busy  out  1  load in progress (states LEN_LO..CSUM)
- done  out  1  sticky: last program ran to halt
- err  out  1  sticky: last load rejected

## Operation
- Frame: 0xA5 start byte, LEN_LO, LEN_HI (word count N, 16-bit), then 4·N data bytes (little-endian per word), then 1 checksum byte.
- Checksum: the XOR of all 4·N data bytes. The start byte and length bytes are excluded.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, RUN, ERR.
- IDLE: s_ready=1, cpu_en=0.
  - A byte of 0xA5 moves to LEN_LO, clears done and err, and clears the checksum, word index and byte index.
  - Any other byte is consumed and dropped.
- LEN_LO / LEN_HI: latch N[7:0] and then N[15:8].
  - After LEN_HI: if N==0 or N>2**ADDR_W, go to ERR; otherwise go to DATA.
- DATA: the byte index (0..3) selects the byte lane of a 32-bit assembly register. Each accepted byte is XORed into the checksum.
  - The 4th byte of a word goes to WRITE.
- WRITE: lasts exactly one cycle.
  - imem_we=1, imem_addr=word index, imem_wdata=assembled word; s_ready=0.
  - The word index increments.
  - If the word index was N-1, go to CSUM; otherwise go to DATA.
- CSUM: one accepted byte. If it equals the checksum, go to RUN; otherwise go to ERR.
- RUN: cpu_en=1, s_ready=0.
  - When cpu_halt=1 is sampled: done=1 and return to IDLE (cpu_en=0).
  - cpu_halt is ignored in all other states.
- ERR: err=1, cpu_en=0, s_ready=1.
  - A byte of 0xA5 restarts the load exactly as from IDLE. Other bytes are dropped.
- Memory contents already written are never erased. A rejected load leaves partially written words in memory.
- The word index is ADDR_W+1 bits wide so that N=2**ADDR_W is legal. imem_addr uses its low ADDR_W bits.

## Timing
- Reset (async): state=IDLE and all counters are 0.
  - Outputs: s_ready=1 from the first edge after release (combinational from state), imem_we=0, imem_addr=0, imem_wdata=0, cpu_en=0, busy=0, done=0, err=0.
- Reset asserted mid-load or mid-run forces the above immediately. cpu_en drops asynchronously.
- s_ready is a function of state only. It never depends combinationally on s_valid.
- Write latency: if the 4th byte of word k is accepted at edge t, imem_we=1 during cycle t..t+1. The memory captures the word at edge t+1. s_ready is low for that cycle only.
- cpu_en rises in the cycle after the edge that accepts a matching checksum byte.
- cpu_en falls in the cycle after the edge on which cpu_halt=1 is sampled in RUN.
- Minimum frame time with s_valid held high: 3 + 5·N + 1 accepted-or-stalled cycles. For N=1 that is 9 edges from the start byte to cpu_en=1.
- done and err are registered, sticky, and mutually exclusive. They are cleared only by an accepted 0xA5 or by reset.
- busy=1 exactly in LEN_LO, LEN_HI, DATA, WRITE and CSUM.

## Test plan
- Single word: A5 01 00 13 00 00 7F, checksum 6C. Required response:
  - One imem_we pulse with addr=0, data=0x7F000013.
  - cpu_en=1 the next cycle after the checksum byte.
  - cpu_halt pulse → cpu_en=0 and done=1.
- Three words with s_valid gaps and random stalls: words 0x11223344, 0xAABBCCDD, 0xFFFFFFFF with the correct XOR checksum. Required response:
  - Writes at addr 0, 1, 2 with exact data.
  - s_ready=0 only in the WRITE cycles.
- Bad checksum: the same single-word frame with checksum 6D. Required response:
  - The word is still written.
  - err=1 and cpu_en stays 0.
  - A following valid frame clears err and runs.
- Length bounds:
  - N=0 → err=1 with no writes.
  - N=2**ADDR_W+1 (ADDR_W=2, N=5) → err=1.
  - N=4 with ADDR_W=2 → 4 writes, addr 0..3, then RUN.
- Garbage and restart: bytes 00 FF 5A in IDLE are dropped with no state change. A start byte followed by an async reset asserted mid-DATA gives:
  - All outputs return to their reset values.
  - A fresh frame loads correctly.
- cpu_halt held high during the load is ignored. In RUN it causes the exit on the first sampled cycle. A new frame reloads and re-enables the core.
